// File: rtl/gen_flanco_pkg.sv
// Shared definitions for the negative-edge generator: state encoding and default
// timing constants tied to the receiver's edge qualifier.
package gen_flanco_pkg;

    localparam logic [1:0] ST_REPOSO = 2'd0;
    localparam logic [1:0] ST_ALTO   = 2'd1;
    localparam logic [1:0] ST_BAJO   = 2'd2;

    typedef enum logic [1:0] {
        REPOSO = ST_REPOSO,
        ALTO   = ST_ALTO,
        BAJO   = ST_BAJO
    } estado_t;

    // The receiver needs at least this many consecutive 1s before the falling edge.
    localparam int MIN_ALTO_DETECTOR = 3;

    localparam int HIGH_CYCLES_DEF = MIN_ALTO_DETECTOR;
    localparam int LOW_CYCLES_DEF  = 4;
    localparam int PEND_MAX_DEF    = 3;
    localparam int PEND_W_DEF      = 2;
    localparam int CNT_W_DEF       = 8;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/contador_fase.sv
// Phase counter shared by the high and low phases: up-counter with clear/enable
// and a terminal flag against a runtime limit.
module contador_fase #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] limite_i,
    output logic [CNT_W-1:0] cuenta_o,
    output logic             fin_o
);

    logic [CNT_W-1:0] cuenta_q, cuenta_d;

    always_comb begin
        cuenta_d = cuenta_q;
        if (clr_i) begin
            cuenta_d = '0;
        end else if (en_i) begin
            cuenta_d = cuenta_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cuenta_q <= '0;
        end else begin
            cuenta_q <= cuenta_d;
        end
    end

    assign cuenta_o = cuenta_q;
    assign fin_o    = (cuenta_q == limite_i);

endmodule

// File: rtl/generador_flanco_negativo.sv
// Turns request strobes into HIGH_CYCLES of 1 followed by LOW_CYCLES of 0 on salida,
// queueing requests that arrive while a press is in progress.
module generador_flanco_negativo
    import gen_flanco_pkg::*;
#(
    parameter int HIGH_CYCLES = HIGH_CYCLES_DEF,
    parameter int LOW_CYCLES  = LOW_CYCLES_DEF,
    parameter int PEND_MAX    = PEND_MAX_DEF,
    parameter int PEND_W      = PEND_W_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              disparo_i,
    output logic              salida_o,
    output logic              ocupado_o,
    output logic              listo_o,
    output logic [PEND_W-1:0] pendiente_o,
    output logic              desborde_o
);

    if (HIGH_CYCLES < MIN_ALTO_DETECTOR) begin : g_chk_high
        $error("HIGH_CYCLES must be at least MIN_ALTO_DETECTOR");
    end
    if (LOW_CYCLES < 1) begin : g_chk_low
        $error("LOW_CYCLES must be at least 1");
    end
    if (PEND_MAX < 1 || PEND_MAX > (2**PEND_W) - 1) begin : g_chk_pend
        $error("PEND_MAX must be in 1 .. 2**PEND_W-1");
    end
    if (max2(HIGH_CYCLES, LOW_CYCLES) - 1 > (2**CNT_W) - 1) begin : g_chk_cnt
        $error("CNT_W too narrow for the phase lengths");
    end

    localparam logic [CNT_W-1:0]  LIM_ALTO   = CNT_W'(HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0]  LIM_BAJO   = CNT_W'(LOW_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX_V = PEND_W'(PEND_MAX);

    estado_t           estado_q, estado_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              salida_q, salida_d;
    logic              ocupado_q, ocupado_d;
    logic              listo_q, listo_d;
    logic              desborde_q, desborde_d;

    logic              cnt_clr, cnt_en, cnt_fin;
    logic [CNT_W-1:0]  cnt, cnt_lim;
    logic              hay_pend, pedido, lanzar, inc, dec;

    contador_fase #(.CNT_W(CNT_W)) u_contador (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .clr_i    (cnt_clr),
        .en_i     (cnt_en),
        .limite_i (cnt_lim),
        .cuenta_o (cnt),
        .fin_o    (cnt_fin)
    );

    always_comb begin
        estado_d   = estado_q;
        pend_d     = pend_q;
        desborde_d = desborde_q;
        lanzar     = 1'b0;
        hay_pend   = (pend_q != '0);
        pedido     = disparo_i | hay_pend;
        cnt_lim    = (estado_q == ALTO) ? LIM_ALTO : LIM_BAJO;

        case (estado_q)
            REPOSO: begin
                if (pedido) begin
                    lanzar   = 1'b1;
                    estado_d = ALTO;
                end
            end
            ALTO: begin
                if (cnt_fin) begin
                    estado_d = BAJO;
                end
            end
            BAJO: begin
                if (cnt_fin) begin
                    if (pedido) begin
                        lanzar   = 1'b1;
                        estado_d = ALTO;
                    end else begin
                        estado_d = REPOSO;
                    end
                end
            end
            default: estado_d = REPOSO;
        endcase

        // A launch with an empty queue consumes disparo directly instead of queueing it.
        dec = lanzar & hay_pend;
        inc = disparo_i & ~(lanzar & ~hay_pend);

        if (inc && !dec) begin
            if (pend_q == PEND_MAX_V) begin
                desborde_d = 1'b1;
            end else begin
                pend_d = pend_q + PEND_W'(1);
            end
        end else if (dec && !inc) begin
            pend_d = pend_q - PEND_W'(1);
        end

        cnt_clr = (estado_d != estado_q) || (estado_q == REPOSO);
        cnt_en  = 1'b1;

        salida_d  = (estado_d == ALTO);
        ocupado_d = (estado_d != REPOSO);
        listo_d   = 1'b0;
        if (estado_d == BAJO) begin
            if (estado_q != BAJO) begin
                listo_d = (LIM_BAJO == '0);
            end else begin
                listo_d = ((cnt + CNT_W'(1)) == LIM_BAJO);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            estado_q   <= REPOSO;
            pend_q     <= '0;
            salida_q   <= 1'b0;
            ocupado_q  <= 1'b0;
            listo_q    <= 1'b0;
            desborde_q <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            pend_q     <= pend_d;
            salida_q   <= salida_d;
            ocupado_q  <= ocupado_d;
            listo_q    <= listo_d;
            desborde_q <= desborde_d;
        end
    end

    assign salida_o    = salida_q;
    assign ocupado_o   = ocupado_q;
    assign listo_o     = listo_q;
    assign pendiente_o = pend_q;
    assign desborde_o  = desborde_q;

endmodule

// File: tb/tb_generador_flanco_negativo.sv
// Self-checking bench for generador_flanco_negativo: directed timing scenarios with a
// per-cycle expectation queue, plus a randomized loopback through an edge qualifier.
module tb_generador_flanco_negativo;

    localparam int H = 3;
    localparam int L = 4;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       disparo_i;
    logic       salida_o;
    logic       ocupado_o;
    logic       listo_o;
    logic [1:0] pendiente_o;
    logic       desborde_o;

    always #5 clk_i = ~clk_i;

    generador_flanco_negativo #(
        .HIGH_CYCLES (H),
        .LOW_CYCLES  (L),
        .PEND_MAX    (3),
        .PEND_W      (2),
        .CNT_W       (8)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .disparo_i   (disparo_i),
        .salida_o    (salida_o),
        .ocupado_o   (ocupado_o),
        .listo_o     (listo_o),
        .pendiente_o (pendiente_o),
        .desborde_o  (desborde_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int         cyc;
        logic [5:0] v;
    } exp_t;

    exp_t sb[$];
    int   dis_cyc[$];
    int   rst_cyc[$];
    int   starts[$];
    int   pend_tab[64];
    int   corte;
    int   d_from;
    int   d_to;

    int   req_q[$];
    int   det_cnt;
    int   listo_cnt;
    logic [2:0] hist;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        reset_i   = 1'b1;
        disparo_i = 1'b0;
        tick();
        tick();
        reset_i = 1'b0;
    endtask

    task automatic setup_clear();
        dis_cyc.delete();
        rst_cyc.delete();
        starts.delete();
        foreach (pend_tab[i]) pend_tab[i] = 0;
        corte  = 1000;
        d_from = 1000;
        d_to   = 1000;
    endtask

    task automatic set_pend(input int a, input int b, input int val);
        for (int i = a; i <= b; i++) pend_tab[i] = val;
    endtask

    // Expectations come from the press start cycles: H high, then L low, listo on the last low.
    task automatic run_dir(input string nm, input int ncyc);
        logic s, o, l, d;
        logic [1:0] p;
        logic [5:0] obs;
        exp_t e;
        sb.delete();
        for (int c = 0; c < ncyc; c++) begin
            s = 1'b0; o = 1'b0; l = 1'b0;
            foreach (starts[k]) begin
                if (c >= starts[k] && c <= starts[k] + H - 1) s = 1'b1;
                if (c >= starts[k] && c <= starts[k] + H + L - 1) o = 1'b1;
                if (c == starts[k] + H + L - 1) l = 1'b1;
            end
            if (c >= corte) begin
                s = 1'b0; o = 1'b0; l = 1'b0;
            end
            p = 2'(pend_tab[c]);
            d = (c >= d_from && c <= d_to);
            sb.push_back('{c, {s, o, l, p, d}});
        end
        for (int c = 0; c < ncyc; c++) begin
            disparo_i = 1'b0;
            reset_i   = 1'b0;
            foreach (dis_cyc[k]) if (dis_cyc[k] == c) disparo_i = 1'b1;
            foreach (rst_cyc[k]) if (rst_cyc[k] == c) reset_i = 1'b1;
            e   = sb.pop_front();
            obs = {salida_o, ocupado_o, listo_o, pendiente_o, desborde_o};
            n_checks++;
            if (obs !== e.v) begin
                n_errors++;
                $display("FAIL %s cycle %0d: got salida=%b ocupado=%b listo=%b pendiente=%0d desborde=%b, expected salida=%b ocupado=%b listo=%b pendiente=%0d desborde=%b",
                         nm, e.cyc, obs[5], obs[4], obs[3], obs[2:1], obs[0],
                         e.v[5], e.v[4], e.v[3], e.v[2:1], e.v[0]);
            end
            tick();
        end
        disparo_i = 1'b0;
        reset_i   = 1'b0;
    endtask

    task automatic test_reset();
        logic [5:0] obs;
        reset_i   = 1'b1;
        disparo_i = 1'b1;
        tick();
        tick();
        obs = {salida_o, ocupado_o, listo_o, pendiente_o, desborde_o};
        n_checks++;
        if (obs !== 6'b0) begin
            n_errors++;
            $display("FAIL reset_state: got %b, expected 000000", obs);
        end
        disparo_i = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        setup_clear();
        dis_cyc = '{5};
        starts  = '{6};
        run_dir("single_press", 16);
    endtask

    task automatic test_queued();
        do_reset();
        setup_clear();
        dis_cyc = '{5, 7, 8};
        starts  = '{6, 13, 20};
        set_pend(8, 8, 1);
        set_pend(9, 12, 2);
        set_pend(13, 19, 1);
        run_dir("queued_presses", 30);
    endtask

    task automatic test_back_to_back();
        do_reset();
        setup_clear();
        dis_cyc = '{5, 7, 12};
        starts  = '{6, 13, 20};
        set_pend(8, 19, 1);
        run_dir("inc_dec_same_cycle", 29);
    endtask

    task automatic test_overflow();
        do_reset();
        setup_clear();
        dis_cyc = '{5, 6, 7, 8, 9, 10};
        starts  = '{6, 13, 20, 27};
        set_pend(7, 7, 1);
        set_pend(8, 8, 2);
        set_pend(9, 12, 3);
        set_pend(13, 19, 2);
        set_pend(20, 26, 1);
        d_from = 10;
        d_to   = 1000;
        run_dir("overflow", 36);
    endtask

    // Runs straight after test_overflow so desborde starts at 1 and must be cleared by reset.
    task automatic test_reset_mid();
        setup_clear();
        dis_cyc = '{5};
        rst_cyc = '{7};
        starts  = '{6};
        corte   = 8;
        d_from  = 0;
        d_to    = 7;
        run_dir("reset_mid_press", 16);
    endtask

    task automatic paso6();
        if (hist == 3'b111 && salida_o == 1'b0) det_cnt++;
        hist = {hist[1:0], salida_o};
        if (listo_o) begin
            listo_cnt++;
            n_checks++;
            if (req_q.size() == 0) begin
                n_errors++;
                $display("FAIL loopback_listo: got listo with no outstanding request, expected none");
            end else begin
                void'(req_q.pop_front());
            end
            n_checks++;
            if (det_cnt !== listo_cnt) begin
                n_errors++;
                $display("FAIL loopback_edge_per_press: got %0d edges, expected %0d", det_cnt, listo_cnt);
            end
        end
        tick();
    endtask

    task automatic test_loopback();
        int gap;
        int k;
        do_reset();
        req_q.delete();
        det_cnt   = 0;
        listo_cnt = 0;
        hist      = 3'b000;
        for (int r = 0; r < 20; r++) begin
            gap = $urandom_range(14, 7);
            for (int g = 0; g < gap; g++) begin
                disparo_i = 1'b0;
                paso6();
            end
            disparo_i = 1'b1;
            req_q.push_back(r);
            paso6();
        end
        disparo_i = 1'b0;
        k = 0;
        while (k < 200 && (ocupado_o || pendiente_o != 2'd0 || req_q.size() != 0)) begin
            paso6();
            k++;
        end
        paso6();
        n_checks++;
        if (k >= 200) begin
            n_errors++;
            $display("FAIL loopback_drain: got still busy after %0d cycles, expected idle", k);
        end
        n_checks++;
        if (det_cnt !== 20) begin
            n_errors++;
            $display("FAIL loopback_edges: got %0d, expected 20", det_cnt);
        end
        n_checks++;
        if (listo_cnt !== 20) begin
            n_errors++;
            $display("FAIL loopback_listo_count: got %0d, expected 20", listo_cnt);
        end
        n_checks++;
        if (desborde_o !== 1'b0) begin
            n_errors++;
            $display("FAIL loopback_desborde: got %b, expected 0", desborde_o);
        end
    endtask

    initial begin
        reset_i   = 1'b1;
        disparo_i = 1'b0;
        test_reset();
        test_single();
        test_queued();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        test_loopback();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
